buzzer_scheduler: RTL and testbench

- Single owner of the clock's one piezo output.
- Arbitrates three requesters: alarm ring, hourly chime pips and key-click beep.
- Sequences the tone and gating pattern for the active requester.
- Sits beside the timekeeping datapath and reads its BCD time and alarm registers.

---
 rtl/clock_pkg.sv | 21 ++
 rtl/tone_gen.sv | 22 ++
 rtl/buzzer_scheduler.sv | 155 +++++++++++++++
 tb/tb_buzzer_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and BCD constants for the clock's buzzer scheduling logic.
package clock_pkg;

    // Enum values double as the src output encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEEP  = 2'd1,
        CHIME = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam logic [7:0] H59 = 8'h59;
    localparam logic [7:0] H55 = 8'h55;
    localparam logic [7:0] H00 = 8'h00;

    // Raw 8-bit compare: BCD :55..:59 are contiguous in binary as well.
    function automatic logic is_pip_sec(input logic [7:0] s);
        return (s >= H55) && (s <= H59);
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Free-running 2-bit divider providing the 512 Hz and 256 Hz piezo tones.
module tone_gen (
    input  logic clk,
    input  logic rst,
    output logic hi,
    output logic lo
);

    logic [1:0] tcnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_reg <= '0;
        end else begin
            tcnt_reg <= tcnt_reg + 2'd1;
        end
    end

    assign hi = tcnt_reg[0];
    assign lo = tcnt_reg[1];

endmodule

// File: rtl/buzzer_scheduler.sv
// Owns the piezo output: arbitrates alarm, hourly chime and key beep,
// and sequences tone/gating for whichever source is active.
module buzzer_scheduler
    import clock_pkg::*;
#(
    parameter int ALARM_SEC    = 20,
    parameter int BEEP_Q       = 2,
    parameter int CHIME_LONG_Q = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       tick_4hz,
    input  logic [7:0] hour,
    input  logic [7:0] min,
    input  logic [7:0] sec,
    input  logic [7:0] a_hour,
    input  logic [7:0] a_min,
    input  logic       alarm_en,
    input  logic       stop,
    input  logic       key_pulse,
    input  logic       mute,
    output logic       buzz,
    output logic [1:0] src,
    output logic       busy
);

    localparam logic [5:0] ALARM_SEC_W    = 6'(ALARM_SEC);
    localparam logic [3:0] BEEP_Q_W       = 4'(BEEP_Q);
    localparam logic [3:0] CHIME_LONG_Q_W = 4'(CHIME_LONG_Q);

    state_t     state_reg, state_next;
    logic [3:0] q_reg, q_next, q_inc;
    logic [5:0] scnt_reg, scnt_next, scnt_inc;
    logic [1:0] phase_reg, phase_next;
    logic       chime_long_reg, chime_long_next;
    logic       buzz_reg, buzz_next;
    logic       busy_reg;
    logic       tone_hi, tone_lo;

    logic alarm_start, pip_start, long_start, chime_start;

    tone_gen u_tone_gen (
        .clk (clk),
        .rst (rst),
        .hi  (tone_hi),
        .lo  (tone_lo)
    );

    assign alarm_start = sec_tick & alarm_en & ~stop & (hour == a_hour)
                         & (min == a_min) & (sec == H00);
    assign pip_start   = sec_tick & (min == H59) & is_pip_sec(sec);
    assign long_start  = sec_tick & (min == H00) & (sec == H00);
    assign chime_start = pip_start | long_start;

    assign q_inc    = q_reg + 4'd1;
    assign scnt_inc = scnt_reg + 6'd1;

    // Quarter phase within the current second; saturates so a missing
    // sec_tick cannot wrap the alarm back into its audible half.
    always_comb begin
        phase_next = phase_reg;
        if (sec_tick) begin
            phase_next = 2'd0;
        end else if (tick_4hz && (phase_reg != 2'd3)) begin
            phase_next = phase_reg + 2'd1;
        end
    end

    always_comb begin
        state_next      = state_reg;
        q_next          = q_reg;
        scnt_next       = scnt_reg;
        chime_long_next = chime_long_reg;

        if (tick_4hz && (state_reg != IDLE)) begin
            q_next = q_inc;
        end
        if (sec_tick && (state_reg == ALARM)) begin
            scnt_next = scnt_inc;
        end

        case (state_reg)
            BEEP: begin
                if (tick_4hz && (q_inc == BEEP_Q_W)) begin
                    state_next = IDLE;
                end
            end
            CHIME: begin
                if (tick_4hz && (!chime_long_reg || (q_inc == CHIME_LONG_Q_W))) begin
                    state_next = IDLE;
                end
            end
            ALARM: begin
                if (stop || !alarm_en || (sec_tick && (scnt_inc == ALARM_SEC_W))) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = state_reg;
            end
        endcase

        // Start events override the per-state sequencing, highest priority first.
        if (alarm_start && (state_reg != ALARM)) begin
            state_next = ALARM;
            q_next     = 4'd0;
            scnt_next  = 6'd0;
        end else if (chime_start && ((state_reg == IDLE) || (state_reg == BEEP))) begin
            state_next      = CHIME;
            q_next          = 4'd0;
            chime_long_next = long_start;
        end else if (key_pulse && (state_reg == IDLE)) begin
            state_next = BEEP;
            q_next     = 4'd0;
        end
    end

    always_comb begin
        buzz_next = 1'b0;
        if (!mute) begin
            case (state_next)
                BEEP:    buzz_next = tone_hi;
                CHIME:   buzz_next = chime_long_next ? tone_hi : tone_lo;
                ALARM:   buzz_next = tone_hi & ~phase_next[1];
                default: buzz_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            q_reg          <= '0;
            scnt_reg       <= '0;
            phase_reg      <= '0;
            chime_long_reg <= 1'b0;
            buzz_reg       <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            q_reg          <= q_next;
            scnt_reg       <= scnt_next;
            phase_reg      <= phase_next;
            chime_long_reg <= chime_long_next;
            buzz_reg       <= buzz_next;
            busy_reg       <= (state_next != IDLE);
        end
    end

    assign src  = state_reg;
    assign buzz = buzz_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Scoreboard bench for buzzer_scheduler: expectations are queued with a target
// cycle as stimulus is driven and checked on the falling edge of that cycle.
module tb_buzzer_scheduler;

    localparam int K_SRC   = 0;
    localparam int K_BUSY  = 1;
    localparam int K_BUZZ  = 2;
    localparam int K_TRANS = 3;

    typedef struct {
        int    cyc;
        string tag;
        int    kind;
        int    exp;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       sec_tick;
    logic       tick_4hz;
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] a_hour;
    logic [7:0] a_min;
    logic       alarm_en;
    logic       stop;
    logic       key_pulse;
    logic       mute;
    logic       buzz;
    logic [1:0] src;
    logic       busy;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic hist [0:8];

    buzzer_scheduler #(
        .ALARM_SEC    (20),
        .BEEP_Q       (2),
        .CHIME_LONG_Q (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sec_tick  (sec_tick),
        .tick_4hz  (tick_4hz),
        .hour      (hour),
        .min       (min),
        .sec       (sec),
        .a_hour    (a_hour),
        .a_min     (a_min),
        .alarm_en  (alarm_en),
        .stop      (stop),
        .key_pulse (key_pulse),
        .mute      (mute),
        .buzz      (buzz),
        .src       (src),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // K_TRANS counts buzz transitions over the last 8 clock pairs:
    // 8 for the 512 Hz tone, 4 for 256 Hz, 0 when silent.
    always @(negedge clk) begin
        int got;
        for (int i = 8; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = buzz;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                case (sb[i].kind)
                    K_SRC:   got = int'(src);
                    K_BUSY:  got = int'(busy);
                    K_BUZZ:  got = int'(buzz);
                    default: begin
                        got = 0;
                        for (int j = 0; j < 8; j++) if (hist[j] !== hist[j+1]) got++;
                    end
                endcase
                if (sb[i].cyc < cyc) got = -1;
                check_value(sb[i].tag, got, sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int at, input string tag, input int kind, input int v);
        exp_t e;
        e.cyc  = at;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
    endfunction

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        hour = h;
        min  = m;
        sec  = s;
    endtask

    task automatic advance_time();
        if (sec == 8'h59) begin
            sec = 8'h00;
            if (min == 8'h59) begin
                min  = 8'h00;
                hour = (hour == 8'h23) ? 8'h00 : bcd_inc(hour);
            end else begin
                min = bcd_inc(min);
            end
        end else begin
            sec = bcd_inc(sec);
        end
    endtask

    // One 64-cycle second: time update at c=0, sec_tick+tick_4hz at c=1,
    // further quarters at c=17/33/49. Optional one-shot key/rst pulses and stop rise.
    task automatic run_second(input int key_off, input int stop_off, input int rst_off);
        for (int c = 0; c < 64; c++) begin
            if (c == 0) advance_time();
            sec_tick  = (c == 1);
            tick_4hz  = (c == 1) || (c == 17) || (c == 33) || (c == 49);
            key_pulse = (c == key_off);
            rst       = (c == rst_off);
            if (c == stop_off) stop = 1'b1;
            step();
        end
        sec_tick  = 1'b0;
        tick_4hz  = 1'b0;
        key_pulse = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        int s0;
        rst = 1'b1; sec_tick = 1'b0; tick_4hz = 1'b0; key_pulse = 1'b0;
        stop = 1'b0; mute = 1'b0; alarm_en = 1'b0;
        a_hour = 8'h00; a_min = 8'h00;
        set_time(8'h10, 8'h20, 8'h30);

        // Reset state
        repeat (3) step();
        s0 = cyc;
        expect_at(s0 + 1, "rst_src", K_SRC, 0);
        expect_at(s0 + 1, "rst_busy", K_BUSY, 0);
        expect_at(s0 + 1, "rst_buzz", K_BUZZ, 0);
        step();
        rst = 1'b0;
        repeat (4) step();

        // Key beep: two quarters of hi tone
        s0 = cyc;
        key_pulse = 1'b1;
        expect_at(s0 + 1, "beep_src", K_SRC, 1);
        expect_at(s0 + 1, "beep_busy", K_BUSY, 1);
        expect_at(s0 + 12, "beep_hi_tone", K_TRANS, 8);
        step();
        key_pulse = 1'b0;
        repeat (19) step();
        s0 = cyc;
        tick_4hz = 1'b1;
        expect_at(s0 + 1, "beep_q1_src", K_SRC, 1);
        step();
        tick_4hz = 1'b0;
        repeat (15) step();
        s0 = cyc;
        tick_4hz = 1'b1;
        expect_at(s0, "beep_q2_pre_src", K_SRC, 1);
        expect_at(s0 + 1, "beep_end_src", K_SRC, 0);
        expect_at(s0 + 1, "beep_end_busy", K_BUSY, 0);
        expect_at(s0 + 1, "beep_end_buzz", K_BUZZ, 0);
        step();
        tick_4hz = 1'b0;
        repeat (5) step();

        // Hourly chime: 12:59:54 -> 13:00:01
        set_time(8'h12, 8'h59, 8'h53);
        s0 = cyc;
        expect_at(s0 + 2, "no_pip_54_src", K_SRC, 0);
        run_second(-1, -1, -1);
        for (int p = 0; p < 5; p++) begin
            s0 = cyc;
            expect_at(s0 + 2, $sformatf("pip%0d_src", p), K_SRC, 2);
            expect_at(s0 + 14, $sformatf("pip%0d_lo_tone", p), K_TRANS, 4);
            expect_at(s0 + 17, $sformatf("pip%0d_hold_src", p), K_SRC, 2);
            expect_at(s0 + 18, $sformatf("pip%0d_end_src", p), K_SRC, 0);
            expect_at(s0 + 20, $sformatf("pip%0d_end_buzz", p), K_BUZZ, 0);
            if (p == 0) expect_at(s0 + 8, "key_in_chime_src", K_SRC, 2);
            run_second((p == 0) ? 6 : -1, -1, -1);
        end
        s0 = cyc;
        expect_at(s0 + 2, "long_src", K_SRC, 2);
        expect_at(s0 + 14, "long_hi_tone_a", K_TRANS, 8);
        expect_at(s0 + 44, "long_hi_tone_b", K_TRANS, 8);
        expect_at(s0 + 50, "long_q3_src", K_SRC, 2);
        run_second(-1, -1, -1);
        s0 = cyc;
        expect_at(s0 + 1, "long_q4_pre_src", K_SRC, 2);
        expect_at(s0 + 2, "long_end_src", K_SRC, 0);
        expect_at(s0 + 2, "long_end_busy", K_BUSY, 0);
        run_second(-1, -1, -1);

        // Alarm ring 07:30:00 .. 07:30:20
        a_hour = 8'h07; a_min = 8'h30; alarm_en = 1'b1;
        set_time(8'h07, 8'h29, 8'h59);
        s0 = cyc;
        expect_at(s0 + 2, "alarm_src", K_SRC, 3);
        expect_at(s0 + 14, "alarm_ph0_tone", K_TRANS, 8);
        expect_at(s0 + 30, "alarm_ph1_tone", K_TRANS, 8);
        expect_at(s0 + 46, "alarm_ph2_silent", K_TRANS, 0);
        expect_at(s0 + 46, "alarm_ph2_buzz", K_BUZZ, 0);
        expect_at(s0 + 62, "alarm_ph3_silent", K_TRANS, 0);
        expect_at(s0 + 62, "alarm_ph3_src", K_SRC, 3);
        run_second(-1, -1, -1);
        for (int s = 1; s < 20; s++) begin
            s0 = cyc;
            if (s == 10 || s == 19) expect_at(s0 + 2, $sformatf("alarm_s%0d_src", s), K_SRC, 3);
            if (s == 10) expect_at(s0 + 14, "alarm_s10_tone", K_TRANS, 8);
            run_second(-1, -1, -1);
        end
        s0 = cyc;
        expect_at(s0 + 1, "alarm_s20_pre_src", K_SRC, 3);
        expect_at(s0 + 2, "alarm_end_src", K_SRC, 0);
        expect_at(s0 + 2, "alarm_end_busy", K_BUSY, 0);
        run_second(-1, -1, -1);

        // Beep at 07:29:59.x preempted by alarm, then stop at 07:30:05
        set_time(8'h07, 8'h29, 8'h58);
        s0 = cyc;
        expect_at(s0 + 42, "pre_beep_src", K_SRC, 1);
        expect_at(s0 + 50, "pre_beep_q1_src", K_SRC, 1);
        expect_at(s0 + 60, "pre_beep_tone", K_TRANS, 8);
        run_second(40, -1, -1);
        s0 = cyc;
        expect_at(s0 + 1, "preempt_pre_src", K_SRC, 1);
        expect_at(s0 + 2, "preempt_src", K_SRC, 3);
        run_second(-1, -1, -1);
        for (int s = 1; s < 5; s++) run_second(-1, -1, -1);
        s0 = cyc;
        expect_at(s0 + 20, "stop_pre_src", K_SRC, 3);
        expect_at(s0 + 21, "stop_src", K_SRC, 0);
        expect_at(s0 + 21, "stop_busy", K_BUSY, 0);
        expect_at(s0 + 21, "stop_buzz", K_BUZZ, 0);
        run_second(-1, 20, -1);
        stop = 1'b0;
        s0 = cyc;
        expect_at(s0 + 2, "stop_no_restart_src", K_SRC, 0);
        run_second(-1, -1, -1);

        // Alarm 14:00 collides with the hourly long tone; mute holds buzz low
        a_hour = 8'h14; a_min = 8'h00;
        set_time(8'h13, 8'h59, 8'h59);
        mute = 1'b1;
        s0 = cyc;
        expect_at(s0 + 2, "coll_src", K_SRC, 3);
        expect_at(s0 + 10, "mute_buzz", K_BUZZ, 0);
        expect_at(s0 + 14, "mute_silent", K_TRANS, 0);
        expect_at(s0 + 40, "mute_src", K_SRC, 3);
        expect_at(s0 + 40, "mute_busy", K_BUSY, 1);
        run_second(-1, -1, -1);
        mute = 1'b0;
        s0 = cyc;
        expect_at(s0 + 2, "coll_s1_src", K_SRC, 3);
        expect_at(s0 + 14, "unmute_tone", K_TRANS, 8);
        run_second(-1, -1, -1);
        s0 = cyc;
        alarm_en = 1'b0;
        expect_at(s0 + 1, "en_fall_src", K_SRC, 0);
        expect_at(s0 + 1, "en_fall_busy", K_BUSY, 0);
        step();
        repeat (4) step();

        // Reset mid-ALARM; no restart without a new qualifying sec_tick
        a_hour = 8'h07; a_min = 8'h30; alarm_en = 1'b1;
        set_time(8'h07, 8'h29, 8'h59);
        s0 = cyc;
        expect_at(s0 + 2, "rst_alarm_src", K_SRC, 3);
        run_second(-1, -1, -1);
        s0 = cyc;
        expect_at(s0 + 30, "rst_pre_src", K_SRC, 3);
        expect_at(s0 + 31, "rst_mid_src", K_SRC, 0);
        expect_at(s0 + 31, "rst_mid_busy", K_BUSY, 0);
        expect_at(s0 + 31, "rst_mid_buzz", K_BUZZ, 0);
        expect_at(s0 + 45, "rst_after_src", K_SRC, 0);
        run_second(-1, -1, 30);
        s0 = cyc;
        expect_at(s0 + 2, "rst_no_restart_src", K_SRC, 0);
        run_second(-1, -1, -1);

        repeat (10) step();
        check_value("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
